// File: rtl/panel_sequencer_if.sv
// CPU-side bus of the panel sequencer: micro-cycle enable, clear, and the
// instruction-boundary handshake (inst_done with the next-instruction PC).
interface panel_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic              cpu_en;
    logic              cpu_clear;
    logic              inst_done;
    logic [ADDR_W-1:0] cpu_pc;

    modport master (
        output cpu_en,
        output cpu_clear,
        input  inst_done,
        input  cpu_pc
    );

    modport slave (
        input  cpu_en,
        input  cpu_clear,
        output inst_done,
        output cpu_pc
    );
endinterface

// File: rtl/panel_sequencer.sv
// Front-panel run/halt/step sequencer: switch sync + debounce, CPU enable gating
// and stretched clear. Optional PC breakpoint under macro PANEL_BREAKPOINT_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_HALTED   | CPU frozen (cpu_en=0), waiting for RUN / STEPI / STEPM
// S_RUNNING  | free run; halts at an instruction boundary on HALT / breakpoint
// S_ISTEP    | runs step_cnt instructions, then halts
// S_MSTEP    | single micro-cycle enable, then halts
// S_CLEARING | cpu_clear held high for CLEAR_LEN cycles
module panel_sequencer #(
    parameter int ADDR_W     = 12,
    parameter int DEBOUNCE   = 4,
    parameter int CLEAR_LEN  = 8,
    parameter int STEP_CNT_W = 8
) (
    input  logic                  SYSCLK,
    input  logic                  RESET_N,
    input  logic                  sw_CLEAR,
    input  logic                  sw_RUN,
    input  logic                  sw_HALT,
    input  logic                  sw_STEPM,
    input  logic                  sw_STEPI,
    input  logic [STEP_CNT_W-1:0] step_count,
    input  logic                  bp_valid,
    input  logic [ADDR_W-1:0]     bp_addr,
    panel_sequencer_if.master     cpu,
    output logic                  running,
    output logic [1:0]            halt_cause
);

    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int CLR_W = $clog2(CLEAR_LEN + 1);

    typedef enum logic [2:0] {
        S_HALTED,
        S_RUNNING,
        S_ISTEP,
        S_MSTEP,
        S_CLEARING
    } state_t;

    state_t                state;
    logic [4:0]            raw;
    logic [4:0]            sync1;
    logic [4:0]            sync2;
    logic [4:0]            deb;
    logic [4:0]            ev;
    logic [DB_W-1:0]       db_cnt [5];
    logic                  ev_clear, ev_halt, ev_run, ev_stepi, ev_stepm;
    logic                  cpu_en_q;
    logic                  cpu_clear_q;
    logic                  halt_pending;
    logic [STEP_CNT_W-1:0] step_cnt;
    logic [CLR_W-1:0]      clr_cnt;
    logic                  boundary;
    logic                  bp_hit;

    // bit index doubles as priority rank: 0 = CLEAR (highest) .. 4 = STEPM
    assign raw = {sw_STEPM, sw_STEPI, sw_RUN, sw_HALT, sw_CLEAR};

    always_ff @(posedge SYSCLK) begin
        if (!RESET_N) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            ev    <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                        ev[i]     <= sync2[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                        ev[i]     <= 1'b0;
                    end
                end else begin
                    db_cnt[i] <= '0;
                    ev[i]     <= 1'b0;
                end
            end
        end
    end

    assign ev_clear = ev[0];
    assign ev_halt  = ev[1] & ~ev[0];
    assign ev_run   = ev[2] & ~(|ev[1:0]);
    assign ev_stepi = ev[3] & ~(|ev[2:0]);
    assign ev_stepm = ev[4] & ~(|ev[3:0]);

    assign boundary = cpu_en_q & cpu.inst_done;

`ifdef PANEL_BREAKPOINT_EN
    // set when resuming from a breakpoint so the first instruction is not re-checked
    logic bp_skip;
    assign bp_hit = bp_valid && (cpu.cpu_pc == bp_addr) && !bp_skip;
`else
    wire unused_bp = ^{bp_valid, bp_addr, cpu.cpu_pc};
    assign bp_hit = 1'b0;
`endif

    always_ff @(posedge SYSCLK) begin
        if (!RESET_N) begin
            state        <= S_HALTED;
            cpu_en_q     <= 1'b0;
            cpu_clear_q  <= 1'b0;
            halt_cause   <= 2'd0;
            halt_pending <= 1'b0;
            step_cnt     <= '0;
            clr_cnt      <= '0;
`ifdef PANEL_BREAKPOINT_EN
            bp_skip      <= 1'b0;
`endif
        end else if (ev_clear) begin
            state        <= S_CLEARING;
            cpu_en_q     <= 1'b0;
            cpu_clear_q  <= 1'b1;
            clr_cnt      <= CLR_W'(CLEAR_LEN - 1);
            halt_pending <= 1'b0;
        end else begin
            case (state)
                S_HALTED: begin
                    if (ev_run) begin
                        state    <= S_RUNNING;
                        cpu_en_q <= 1'b1;
                    end else if (ev_stepi) begin
                        state    <= S_ISTEP;
                        cpu_en_q <= 1'b1;
                        step_cnt <= (step_count == '0) ? STEP_CNT_W'(1) : step_count;
                    end else if (ev_stepm) begin
                        state    <= S_MSTEP;
                        cpu_en_q <= 1'b1;
                    end
`ifdef PANEL_BREAKPOINT_EN
                    if (ev_run || ev_stepi || ev_stepm) bp_skip <= (halt_cause == 2'd3);
`endif
                end
                S_MSTEP: begin
                    state      <= S_HALTED;
                    cpu_en_q   <= 1'b0;
                    halt_cause <= 2'd2;
                end
                S_RUNNING, S_ISTEP: begin
                    if (ev_halt) halt_pending <= 1'b1;
                    if (boundary) begin
`ifdef PANEL_BREAKPOINT_EN
                        bp_skip <= 1'b0;
`endif
                        if (state == S_ISTEP) step_cnt <= step_cnt - STEP_CNT_W'(1);
                        if (bp_hit || halt_pending ||
                            (state == S_ISTEP && step_cnt == STEP_CNT_W'(1))) begin
                            state        <= S_HALTED;
                            cpu_en_q     <= 1'b0;
                            halt_pending <= 1'b0;
                            halt_cause   <= bp_hit ? 2'd3 : (halt_pending ? 2'd1 : 2'd2);
                        end
                    end
                end
                S_CLEARING: begin
                    if (clr_cnt == '0) begin
                        state        <= S_HALTED;
                        cpu_clear_q  <= 1'b0;
                        halt_cause   <= 2'd0;
                        halt_pending <= 1'b0;
                        step_cnt     <= '0;
                    end else begin
                        clr_cnt <= clr_cnt - CLR_W'(1);
                    end
                end
                default: begin
                    state       <= S_HALTED;
                    cpu_en_q    <= 1'b0;
                    cpu_clear_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu.cpu_en    = cpu_en_q;
    assign cpu.cpu_clear = cpu_clear_q;
    assign running       = (state == S_RUNNING) || (state == S_ISTEP);

endmodule
